// File: rtl/pintar_blanco.sv
// Canvas-clear writer: walks the framebuffer (or a latched rectangle when
// PINTAR_BLANCO_RECT_EN is defined) and writes WHITE through a valid/ready port.
module pintar_blanco #(
    parameter int                 H_RES   = 64,
    parameter int                 V_RES   = 64,
    parameter int                 ADDR_W  = 12,
    parameter int                 COLOR_W = 24,
    parameter logic [COLOR_W-1:0] WHITE   = COLOR_W'(24'hFFFFFF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               wr_ready,
`ifdef PINTAR_BLANCO_RECT_EN
    input  logic [ADDR_W-1:0]  x0,
    input  logic [ADDR_W-1:0]  y0,
    input  logic [ADDR_W-1:0]  x1,
    input  logic [ADDR_W-1:0]  y1,
`endif
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic [23:0]        cont_cursor,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] H_LAST  = ADDR_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] V_LAST  = ADDR_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  x_q, x_d;
    logic [ADDR_W-1:0]  y_q, y_d;
    logic [23:0]        cnt_q, cnt_d;

    // Walk bounds: start point sampled at init, wrap/stop bounds used during the walk.
    logic [ADDR_W-1:0]  start_x, start_y;
    logic [ADDR_W-1:0]  lo_x, hi_x, hi_y;
    logic               start_bad;
    logic               start_walk;

`ifdef PINTAR_BLANCO_RECT_EN
    logic [ADDR_W-1:0]  lx_q, lx_d;
    logic [ADDR_W-1:0]  hx_q, hx_d;
    logic [ADDR_W-1:0]  hy_q, hy_d;

    always_comb begin
        start_x   = x0;
        start_y   = y0;
        lo_x      = lx_q;
        hi_x      = hx_q;
        hi_y      = hy_q;
        start_bad = (x0 > x1) || (y0 > y1) || (x1 > H_LAST) || (y1 > V_LAST);
        lx_d      = start_walk ? x0 : lx_q;
        hx_d      = start_walk ? x1 : hx_q;
        hy_d      = start_walk ? y1 : hy_q;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            lx_q <= '0;
            hx_q <= '0;
            hy_q <= '0;
        end else begin
            lx_q <= lx_d;
            hx_q <= hx_d;
            hy_q <= hy_d;
        end
    end
`else
    always_comb begin
        start_x   = '0;
        start_y   = '0;
        lo_x      = '0;
        hi_x      = H_LAST;
        hi_y      = V_LAST;
        start_bad = 1'b0;
    end
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        start_walk = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (init) begin
                    start_walk = 1'b1;
                    x_d        = start_x;
                    y_d        = start_y;
                    cnt_d      = '0;
                    state_d    = start_bad ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ready) begin
                    cnt_d = cnt_q + 24'd1;
                    if (x_q == hi_x) begin
                        x_d = lo_x;
                        if (y_q == hi_y) begin
                            state_d = S_DONE;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                x_d     = '0;
                y_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // The whole block advances on the falling edge of clk.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        busy        = 1'b0;
        done        = 1'b0;
        cont_cursor = '0;
        case (state_q)
            S_WRITE: begin
                wr_en       = 1'b1;
                busy        = 1'b1;
                wr_data     = WHITE;
                wr_addr     = y_q * H_RES_A + x_q;
                cont_cursor = cnt_q;
            end
            S_DONE: begin
                done        = 1'b1;
                cont_cursor = cnt_q;
            end
            default: begin
                cont_cursor = '0;
            end
        endcase
    end

endmodule
